exe_stage_mdu: RTL and testbench

- Parametrised next-generation Minisys execute stage with the EX/MEM pipeline register built in.
- Adds operand forwarding, stall/flush/bubble control, overflow detection and a multi-cycle multiply/divide unit (MDU) with HI/LO registers.
- Sits between the ID/EX register and the MEM stage.
- Raises stall_ex upstream while the MDU is busy and a dependent instruction sits in E.

---
 rtl/exe_stage_mdu_if.sv | 61 ++++++
 rtl/exe_stage_mdu.sv | 230 +++++++++++++++++++++++
 tb/tb_exe_stage_mdu.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_mdu_if.sv
// E-stage inputs and EX/MEM outputs of the Minisys execute stage.
// The master drives the E stage (ID/EX side); the slave is the execute stage.
interface exe_stage_mdu_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) ();
  logic              in_valid;
  logic              flush;
  logic              mem_stall;
  logic [4:0]        op;
  logic              alusrc;
  logic              regdst;
  logic              regwrite_e;
  logic              mem2reg_e;
  logic [3:0]        memwrite_e;
  logic              op_beq_e;
  logic              op_bne_e;
  logic              jump_e;
  logic [XLEN-1:0]   rd1_e;
  logic [XLEN-1:0]   rd2_e;
  logic [XLEN-1:0]   imm_e;
  logic [XLEN-1:0]   pcplus4_e;
  logic [XLEN-1:0]   fwd_m;
  logic [XLEN-1:0]   fwd_w;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [REG_AW-1:0] rt_e;
  logic [REG_AW-1:0] rd_e;

  logic              stall_ex;
  logic              mdu_busy;
  logic              valid_m;
  logic              regwrite_m;
  logic              mem2reg_m;
  logic              branch_m;
  logic              jump_m;
  logic              zero_m;
  logic              overflow_m;
  logic [3:0]        memwrite_m;
  logic [REG_AW-1:0] write_reg_m;
  logic [XLEN-1:0]   alu_out_m;
  logic [XLEN-1:0]   write_data_m;
  logic [XLEN-1:0]   pc_branch_m;
  logic [XLEN-1:0]   pcplus4_m;

  modport master (
    output in_valid, flush, mem_stall, op, alusrc, regdst, regwrite_e, mem2reg_e, memwrite_e,
           op_beq_e, op_bne_e, jump_e, rd1_e, rd2_e, imm_e, pcplus4_e, fwd_m, fwd_w,
           fwd_a_sel, fwd_b_sel, rt_e, rd_e,
    input  stall_ex, mdu_busy, valid_m, regwrite_m, mem2reg_m, branch_m, jump_m, zero_m,
           overflow_m, memwrite_m, write_reg_m, alu_out_m, write_data_m, pc_branch_m, pcplus4_m
  );

  modport slave (
    input  in_valid, flush, mem_stall, op, alusrc, regdst, regwrite_e, mem2reg_e, memwrite_e,
           op_beq_e, op_bne_e, jump_e, rd1_e, rd2_e, imm_e, pcplus4_e, fwd_m, fwd_w,
           fwd_a_sel, fwd_b_sel, rt_e, rd_e,
    output stall_ex, mdu_busy, valid_m, regwrite_m, mem2reg_m, branch_m, jump_m, zero_m,
           overflow_m, memwrite_m, write_reg_m, alu_out_m, write_data_m, pc_branch_m, pcplus4_m
  );
endinterface

// File: rtl/exe_stage_mdu.sv
// Minisys execute stage: forwarding, ALU, branch target, HI/LO with an iterative
// multiply/divide unit, and the EX/MEM pipeline register.
module exe_stage_mdu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 6
) (
  input logic             clk,
  input logic             clrn,
  exe_stage_mdu_if.slave  bus
);
  localparam int unsigned M = XLEN - 1;

  localparam logic [4:0] OpAdd  = 5'd0,  OpAddu  = 5'd1,  OpSub  = 5'd2,  OpSubu = 5'd3;
  localparam logic [4:0] OpAnd  = 5'd4,  OpOr    = 5'd5,  OpXor  = 5'd6,  OpNor  = 5'd7;
  localparam logic [4:0] OpSlt  = 5'd8,  OpSltu  = 5'd9,  OpSll  = 5'd10, OpSrl  = 5'd11;
  localparam logic [4:0] OpSra  = 5'd12, OpLui   = 5'd13, OpMfhi = 5'd20, OpMflo = 5'd21;
  localparam logic [4:0] OpMthi = 5'd22, OpMtlo  = 5'd23;

  typedef enum logic [0:0] {StIdle, StBusy} mdu_state_e;

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  // Working registers: acc = product high / partial remainder, wlo = multiplier / quotient,
  // wb = multiplicand / divisor magnitude.
  logic [XLEN-1:0]   acc_q, acc_d, wlo_q, wlo_d, wb_q, wb_d, dvd_q, dvd_d;
  logic              is_div_q, is_div_d, neg_q, neg_d, negr_q, negr_d, div0_q, div0_d;

  logic [XLEN-1:0]   opa, opb, rt_val, sum, diff, alu_res, mag_a, mag_b;
  logic [XLEN-1:0]   acc_step, wlo_step;
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] prod;
  logic [4:0]        shamt;
  logic              ovf, zero, advance, mdu_start, sgn;

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] r,
                                               input logic [XLEN-1:0] fm,
                                               input logic [XLEN-1:0] fw);
    case (sel)
      2'd1:    return fm;
      2'd2:    return fw;
      default: return r;
    endcase
  endfunction

  assign opa    = fwd_mux(bus.fwd_a_sel, bus.rd1_e, bus.fwd_m, bus.fwd_w);
  assign rt_val = fwd_mux(bus.fwd_b_sel, bus.rd2_e, bus.fwd_m, bus.fwd_w);
  assign opb    = bus.alusrc ? bus.imm_e : rt_val;
  assign sum    = opa + opb;
  assign diff   = opa - opb;
  assign zero   = (diff == '0);
  assign shamt  = 5'(bus.imm_e >> 6);

  assign bus.mdu_busy = (state_q == StBusy);
  assign bus.stall_ex = bus.mdu_busy & bus.in_valid & (bus.op inside {[5'd16:5'd23]});
  assign advance      = bus.in_valid & ~bus.flush & ~bus.stall_ex & ~bus.mem_stall;
  assign mdu_start    = advance & (bus.op inside {[5'd16:5'd19]});

  always_comb begin
    alu_res = '0;
    ovf     = 1'b0;
    case (bus.op)
      OpAdd: begin
        alu_res = sum;
        ovf     = (opa[M] == opb[M]) && (sum[M] != opa[M]);
      end
      OpAddu: alu_res = sum;
      OpSub: begin
        alu_res = diff;
        ovf     = (opa[M] != opb[M]) && (diff[M] != opa[M]);
      end
      OpSubu: alu_res = diff;
      OpAnd:  alu_res = opa & opb;
      OpOr:   alu_res = opa | opb;
      OpXor:  alu_res = opa ^ opb;
      OpNor:  alu_res = ~(opa | opb);
      OpSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      OpSltu: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      OpSll:  alu_res = opb << shamt;
      OpSrl:  alu_res = opb >> shamt;
      OpSra:  alu_res = $signed(opb) >>> shamt;
      OpLui:  alu_res = bus.imm_e << (XLEN / 2);
      OpMfhi: alu_res = hi_q;
      OpMflo: alu_res = lo_q;
      default: ;
    endcase
  end

  // MULT/DIV variants: op[1] selects divide, op[0] selects unsigned.
  assign sgn   = ~bus.op[0];
  assign mag_a = (sgn & opa[M]) ? -opa : opa;
  assign mag_b = (sgn & rt_val[M]) ? -rt_val : rt_val;

  assign mul_sum   = {1'b0, acc_q} + (wlo_q[0] ? {1'b0, wb_q} : '0);
  assign div_trial = {acc_q, wlo_q[M]} - {1'b0, wb_q};

  always_comb begin
    if (is_div_q) begin
      if (!div_trial[XLEN]) begin
        acc_step = div_trial[XLEN-1:0];
        wlo_step = {wlo_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[XLEN-2:0], wlo_q[M]};
        wlo_step = {wlo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step = mul_sum[XLEN:1];
      wlo_step = {mul_sum[0], wlo_q[XLEN-1:1]};
    end
  end

  assign prod = neg_q ? -{acc_step, wlo_step} : {acc_step, wlo_step};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    wlo_d    = wlo_q;
    wb_d     = wb_q;
    dvd_d    = dvd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      StIdle: begin
        if (mdu_start) begin
          state_d  = StBusy;
          cnt_d    = CNT_W'(XLEN);
          acc_d    = '0;
          wlo_d    = mag_a;
          wb_d     = mag_b;
          dvd_d    = opa;
          is_div_d = bus.op[1];
          neg_d    = sgn & (opa[M] ^ rt_val[M]);
          negr_d   = sgn & opa[M];
          div0_d   = (rt_val == '0);
        end
      end
      StBusy: begin
        acc_d = acc_step;
        wlo_d = wlo_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          if (!is_div_q) begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end else if (div0_q) begin
            hi_d = dvd_q;
            lo_d = '1;
          end else begin
            hi_d = negr_q ? -acc_step : acc_step;
            lo_d = neg_q ? -wlo_step : wlo_step;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // MTHI/MTLO are stalled while busy, so they never collide with the final MDU write.
    if (advance && bus.op == OpMthi) hi_d = opa;
    if (advance && bus.op == OpMtlo) lo_d = opa;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      wlo_q    <= '0;
      wb_q     <= '0;
      dvd_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      wlo_q    <= wlo_d;
      wb_q     <= wb_d;
      dvd_q    <= dvd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // EX/MEM register; control fields are gated by advance so a non-advancing slot is a bubble.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bus.valid_m      <= 1'b0;
      bus.regwrite_m   <= 1'b0;
      bus.mem2reg_m    <= 1'b0;
      bus.branch_m     <= 1'b0;
      bus.jump_m       <= 1'b0;
      bus.zero_m       <= 1'b0;
      bus.overflow_m   <= 1'b0;
      bus.memwrite_m   <= '0;
      bus.write_reg_m  <= '0;
      bus.alu_out_m    <= '0;
      bus.write_data_m <= '0;
      bus.pc_branch_m  <= '0;
      bus.pcplus4_m    <= '0;
    end else if (!bus.mem_stall) begin
      bus.valid_m      <= advance;
      bus.regwrite_m   <= advance & bus.regwrite_e;
      bus.mem2reg_m    <= bus.mem2reg_e;
      bus.branch_m     <= advance & ((bus.op_beq_e & zero) | (bus.op_bne_e & ~zero));
      bus.jump_m       <= advance & bus.jump_e;
      bus.zero_m       <= zero;
      bus.overflow_m   <= advance & ovf;
      bus.memwrite_m   <= advance ? bus.memwrite_e : 4'b0000;
      bus.write_reg_m  <= bus.regdst ? bus.rt_e : bus.rd_e;
      bus.alu_out_m    <= alu_res;
      bus.write_data_m <= rt_val;
      bus.pc_branch_m  <= bus.pcplus4_e + (bus.imm_e << 2);
      bus.pcplus4_m    <= bus.pcplus4_e;
    end
  end
endmodule

// File: tb/tb_exe_stage_mdu.sv
// Directed bench for exe_stage_mdu: ALU vector table plus MDU, stall, flush and reset sequences.
module tb_exe_stage_mdu;
  localparam logic [4:0] OpAdd = 5'd0, OpAddu = 5'd1, OpSub = 5'd2, OpSubu = 5'd3;
  localparam logic [4:0] OpAnd = 5'd4, OpOr = 5'd5, OpXor = 5'd6, OpNor = 5'd7;
  localparam logic [4:0] OpSlt = 5'd8, OpSltu = 5'd9, OpSll = 5'd10, OpSrl = 5'd11;
  localparam logic [4:0] OpSra = 5'd12, OpLui = 5'd13, OpMult = 5'd16, OpDiv = 5'd18;
  localparam logic [4:0] OpDivu = 5'd19, OpMfhi = 5'd20, OpMflo = 5'd21;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  exe_stage_mdu_if #(.XLEN(32), .REG_AW(5)) bus ();

  exe_stage_mdu #(.XLEN(32), .REG_AW(5), .CNT_W(6)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  typedef struct {
    logic [4:0]  op;
    logic        alusrc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        beq;
    logic        bne;
    logic [31:0] exp_alu;
    logic        exp_z;
    logic        exp_ovf;
    logic        exp_br;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [4:0] op, logic alusrc, logic [1:0] fa, logic [1:0] fb,
                              logic [31:0] a, logic [31:0] b, logic [31:0] imm, logic beq,
                              logic bne, logic [31:0] exp_alu, logic exp_z, logic exp_ovf,
                              logic exp_br);
    vec_t v;
    v.op = op; v.alusrc = alusrc; v.fa = fa; v.fb = fb; v.a = a; v.b = b; v.imm = imm;
    v.beq = beq; v.bne = bne; v.exp_alu = exp_alu; v.exp_z = exp_z; v.exp_ovf = exp_ovf;
    v.exp_br = exp_br;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.mem_stall = 1'b0; bus.op = OpAdd;
    bus.alusrc = 1'b0; bus.regdst = 1'b0; bus.regwrite_e = 1'b0; bus.mem2reg_e = 1'b0;
    bus.memwrite_e = 4'h0; bus.op_beq_e = 1'b0; bus.op_bne_e = 1'b0; bus.jump_e = 1'b0;
    bus.rd1_e = '0; bus.rd2_e = '0; bus.imm_e = '0; bus.pcplus4_e = 32'h100;
    bus.fwd_m = 32'h10; bus.fwd_w = 32'h20; bus.fwd_a_sel = 2'd0; bus.fwd_b_sel = 2'd0;
    bus.rt_e = 5'd3; bus.rd_e = 5'd9;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    idle();
    bus.in_valid = 1'b1; bus.regwrite_e = 1'b1; bus.op = op; bus.rd1_e = a; bus.rd2_e = b;
  endtask

  // Counts cycles that stall_ex holds the presented instruction, bounded at 40.
  task automatic count_stall(output int n);
    n = 0;
    #1;
    while (bus.stall_ex && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    idle();
    vecs.push_back(mk(OpAdd,  0, 0, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 32'h80000000, 0, 1, 0));
    vecs.push_back(mk(OpAddu, 0, 0, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 32'h80000000, 0, 0, 0));
    vecs.push_back(mk(OpSub,  0, 0, 0, 32'h80000000, 32'h1, 0, 0, 0, 32'h7FFFFFFF, 0, 1, 0));
    vecs.push_back(mk(OpSubu, 0, 0, 0, 32'h5, 32'h5, 0, 0, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(OpAnd,  0, 0, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 32'h00F000F0, 0, 0, 0));
    vecs.push_back(mk(OpOr,   0, 0, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 32'hFFF0FFF0, 0, 0, 0));
    vecs.push_back(mk(OpXor,  0, 0, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 32'hFF00FF00, 0, 0, 0));
    vecs.push_back(mk(OpNor,  0, 0, 0, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 32'h000F000F, 0, 0, 0));
    vecs.push_back(mk(OpSlt,  0, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h1, 0, 0, 0));
    vecs.push_back(mk(OpSltu, 0, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(OpSll,  0, 0, 0, 32'h0, 32'h1, 32'h100, 0, 0, 32'h10, 0, 0, 0));
    vecs.push_back(mk(OpSrl,  0, 0, 0, 32'h0, 32'h80000000, 32'h100, 0, 0, 32'h08000000, 0, 0, 0));
    vecs.push_back(mk(OpSra,  0, 0, 0, 32'h0, 32'h80000000, 32'h100, 0, 0, 32'hF8000000, 0, 0, 0));
    vecs.push_back(mk(OpLui,  1, 0, 0, 32'h0, 32'h0, 32'h1234, 0, 0, 32'h12340000, 0, 0, 0));
    vecs.push_back(mk(OpSub,  0, 0, 0, 32'h5, 32'h5, 32'hFFFFFFFF, 0, 1, 32'h0, 1, 0, 0));
    vecs.push_back(mk(OpSub,  0, 0, 0, 32'h5, 32'h5, 32'hFFFFFFFF, 1, 0, 32'h0, 1, 0, 1));
    vecs.push_back(mk(OpAdd,  0, 1, 2, 32'h0, 32'h0, 0, 0, 0, 32'h30, 0, 0, 0));
    vecs.push_back(mk(OpAdd,  0, 3, 3, 32'h4, 32'h5, 0, 0, 0, 32'h9, 0, 0, 0));
    vecs.push_back(mk(OpAddu, 1, 0, 2, 32'h10, 32'h0, 32'hFFFFFFF0, 0, 0, 32'h0, 0, 0, 0));

    // Reset state
    tick(); tick();
    chk("rst_valid_m", {31'b0, bus.valid_m}, 0);
    chk("rst_alu_out_m", bus.alu_out_m, 0);
    chk("rst_mdu_busy", {31'b0, bus.mdu_busy}, 0);
    clrn = 1'b1;
    tick();

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      bus.alusrc = vecs[i].alusrc; bus.fwd_a_sel = vecs[i].fa; bus.fwd_b_sel = vecs[i].fb;
      bus.imm_e = vecs[i].imm; bus.op_beq_e = vecs[i].beq; bus.op_bne_e = vecs[i].bne;
      bus.regdst = i[0];
      tick();
      chk($sformatf("v%0d_alu", i), bus.alu_out_m, vecs[i].exp_alu);
      chk($sformatf("v%0d_zero", i), {31'b0, bus.zero_m}, {31'b0, vecs[i].exp_z});
      chk($sformatf("v%0d_ovf", i), {31'b0, bus.overflow_m}, {31'b0, vecs[i].exp_ovf});
      chk($sformatf("v%0d_br", i), {31'b0, bus.branch_m}, {31'b0, vecs[i].exp_br});
      chk($sformatf("v%0d_pcb", i), bus.pc_branch_m, 32'h100 + (vecs[i].imm << 2));
      chk($sformatf("v%0d_wreg", i), {27'b0, bus.write_reg_m}, i[0] ? 32'd3 : 32'd9);
      chk($sformatf("v%0d_valid", i), {31'b0, bus.valid_m}, 1);
    end
    chk("bne_pcb_fc", vecs[14].imm << 2, 32'hFFFFFFFC);

    // MULT -3 x 7 followed directly by MFLO
    issue(OpMult, 32'hFFFFFFFD, 32'd7);
    tick();
    chk("mult_busy", {31'b0, bus.mdu_busy}, 1);
    issue(OpMflo, 0, 0);
    count_stall(n);
    chk("mult_stall_cycles", n, 32);
    tick();
    chk("mflo_mult", bus.alu_out_m, 32'hFFFFFFEB);
    chk("mflo_valid", {31'b0, bus.valid_m}, 1);
    issue(OpMfhi, 0, 0);
    tick();
    chk("mfhi_mult", bus.alu_out_m, 32'hFFFFFFFF);

    // DIV -7/2 with an independent ADD in the shadow
    issue(OpDiv, 32'hFFFFFFF9, 32'd2);
    tick();
    issue(OpAdd, 32'd2, 32'd3);
    #1;
    chk("add_no_stall", {31'b0, bus.stall_ex}, 0);
    tick();
    chk("add_shadow_alu", bus.alu_out_m, 32'd5);
    issue(OpMflo, 0, 0);
    count_stall(n);
    chk("div_stall_cycles", n, 31);
    tick();
    chk("mflo_div", bus.alu_out_m, 32'hFFFFFFFD);
    issue(OpMfhi, 0, 0);
    tick();
    chk("mfhi_div", bus.alu_out_m, 32'hFFFFFFFF);

    // DIVU 9/0
    issue(OpDivu, 32'd9, 32'd0);
    tick();
    issue(OpMflo, 0, 0);
    count_stall(n);
    chk("divu0_stall_cycles", n, 32);
    tick();
    chk("mflo_div0", bus.alu_out_m, 32'hFFFFFFFF);
    issue(OpMfhi, 0, 0);
    tick();
    chk("mfhi_div0", bus.alu_out_m, 32'd9);

    // Reset at BUSY cycle 10 while ADDs keep flowing
    issue(OpMult, 32'd3, 32'd5);
    tick();
    issue(OpAdd, 32'h11, 32'h22);
    repeat (9) tick();
    chk("pre_rst_busy", {31'b0, bus.mdu_busy}, 1);
    chk("pre_rst_alu", bus.alu_out_m, 32'h33);
    clrn = 1'b0;
    #1;
    chk("rst_busy_now", {31'b0, bus.mdu_busy}, 0);
    chk("rst_valid_now", {31'b0, bus.valid_m}, 0);
    chk("rst_regwrite_now", {31'b0, bus.regwrite_m}, 0);
    chk("rst_alu_now", bus.alu_out_m, 0);
    tick();
    clrn = 1'b1;
    issue(OpMfhi, 0, 0);
    tick();
    chk("rst_hi", bus.alu_out_m, 0);
    issue(OpMflo, 0, 0);
    tick();
    chk("rst_lo", bus.alu_out_m, 0);
    chk("rst_busy_after", {31'b0, bus.mdu_busy}, 0);

    // mem_stall freezes M for 3 cycles
    issue(OpOr, 32'hA0, 32'h0A);
    tick();
    chk("or_aa", bus.alu_out_m, 32'hAA);
    issue(OpAdd, 32'd2, 32'd3);
    bus.mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mstall_hold%0d", k), bus.alu_out_m, 32'hAA);
    end
    bus.mem_stall = 1'b0;
    tick();
    chk("mstall_release", bus.alu_out_m, 32'd5);
    chk("mstall_release_valid", {31'b0, bus.valid_m}, 1);

    // MULT held by mem_stall or killed by flush never starts
    issue(OpMult, 32'd3, 32'd5);
    bus.mem_stall = 1'b1;
    tick();
    chk("mult_mstall_nostart", {31'b0, bus.mdu_busy}, 0);
    issue(OpMult, 32'd3, 32'd5);
    bus.flush = 1'b1;
    tick();
    chk("mult_flush_nostart", {31'b0, bus.mdu_busy}, 0);

    // Flushed SW becomes a bubble; unflushed SW stores
    issue(OpAdd, 32'h100, 32'hDEAD);
    bus.alusrc = 1'b1; bus.imm_e = 32'd8; bus.memwrite_e = 4'hF; bus.regwrite_e = 1'b0;
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, bus.valid_m}, 0);
    chk("flush_memwrite", {28'b0, bus.memwrite_m}, 0);
    bus.flush = 1'b0;
    tick();
    chk("sw_valid", {31'b0, bus.valid_m}, 1);
    chk("sw_memwrite", {28'b0, bus.memwrite_m}, 32'hF);
    chk("sw_wdata", bus.write_data_m, 32'hDEAD);
    chk("sw_addr", bus.alu_out_m, 32'h108);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
